// File: rtl/serial_mul_param_if.sv
// rtl/serial_mul_param_if.sv - operand/product handshake bundle for serial_mul_param
interface serial_mul_param_if #(
  parameter int A_W = 1024,
  parameter int B_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [A_W-1:0]     in_a;
  logic [B_W-1:0]     in_b;
  logic               out_valid;
  logic               out_ready;
  logic [A_W+B_W-1:0] out_p;
  logic               busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/serial_mul_param.sv
// rtl/serial_mul_param.sv - multi-cycle shift-add multiplier, STEP multiplier bits per clock
// Signed mode sign-extends the multiplicand and subtracts the multiplier MSB term.
module serial_mul_param #(
  parameter int A_W  = 1024,
  parameter int B_W  = 32,
  parameter int STEP = 1
) (
  input logic                clk,
  input logic                rstn,
  serial_mul_param_if.slave  bus
);
  localparam int P_W   = A_W + B_W;
  localparam int N     = B_W / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4) || (B_W % STEP) != 0) begin : g_bad_param
      $fatal(1, "serial_mul_param: STEP must be 1, 2 or 4 and divide B_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_W-1:0]     acc_q, acc_d;
  logic [P_W-1:0]     a_q, a_d;
  logic [B_W-1:0]     b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [P_W-1:0]     out_p_q, out_p_d;

  logic               last_step;
  logic [P_W-1:0]     step_sum;
  logic [P_W-1:0]     term;
  logic               in_ready_c;
  logic               busy_c;
  logic               out_valid_c;

  assign last_step = (cnt_q == CNT_W'(N - 1));

  // In the final step of a signed op the top multiplier bit carries weight -2^(B_W-1).
  always_comb begin
    step_sum = acc_q;
    term     = '0;
    for (int k = 0; k < STEP; k++) begin
      term = a_q << k;
      if (b_q[k]) begin
        if (sgn_q && last_step && (k == STEP - 1)) begin
          step_sum = step_sum - term;
        end else begin
          step_sum = step_sum + term;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    out_p_d     = out_p_q;
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          sgn_d   = bus.in_signed;
          a_d     = {{B_W{bus.in_signed & bus.in_a[A_W-1]}}, bus.in_a};
          b_d     = bus.in_b;
        end
      end
      S_RUN: begin
        busy_c = 1'b1;
        acc_d  = step_sum;
        a_d    = a_q << STEP;
        b_d    = b_q >> STEP;
        cnt_d  = cnt_q + 1'b1;
        if (last_step) begin
          state_d = S_DONE;
          cnt_d   = '0;
          out_p_d = step_sum;
        end
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      out_p_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      out_p_q <= out_p_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_serial_mul_param.sv
// tb/tb_serial_mul_param.sv - directed and model-checked bench for serial_mul_param
module tb_serial_mul_param;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_mul_param_if #(.A_W(8), .B_W(8)) i1 ();
  serial_mul_param_if #(.A_W(8), .B_W(8)) i2 ();
  serial_mul_param_if i3 ();

  serial_mul_param #(.A_W(8), .B_W(8), .STEP(1)) u1 (.clk(clk), .rstn(rstn), .bus(i1));
  serial_mul_param #(.A_W(8), .B_W(8), .STEP(2)) u2 (.clk(clk), .rstn(rstn), .bus(i2));
  serial_mul_param u3 (.clk(clk), .rstn(rstn), .bus(i3));

  function automatic logic [1055:0] ref_mul(input logic sg, input logic [1023:0] a, input logic [31:0] b);
    logic signed [1055:0] sa, sb;
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'b0, a};
      sb = {1024'b0, b};
    end
    return sa * sb;
  endfunction

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    checks++; if ({i1.in_ready, i1.busy, i1.out_valid} !== 3'b100) begin errors++; $display("FAIL reset_i1_ctl got %b exp 100", {i1.in_ready, i1.busy, i1.out_valid}); end
    checks++; if (i1.out_p !== 16'h0) begin errors++; $display("FAIL reset_i1_p got %h exp 0000", i1.out_p); end
    checks++; if ({i2.in_ready, i2.busy, i2.out_valid} !== 3'b100) begin errors++; $display("FAIL reset_i2_ctl got %b exp 100", {i2.in_ready, i2.busy, i2.out_valid}); end
    checks++; if ({i3.in_ready, i3.busy, i3.out_valid} !== 3'b100) begin errors++; $display("FAIL reset_i3_ctl got %b exp 100", {i3.in_ready, i3.busy, i3.out_valid}); end
    checks++; if (i3.out_p !== '0) begin errors++; $display("FAIL reset_i3_p got nonzero exp 0"); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Launch one 8x8 op on i1 (s2=0) or i2 (s2=1), check latency, product and consumption.
  task automatic op8(input logic s2, input logic sg, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input int lat, input string nm);
    int n;
    logic ov, rdy;
    logic [15:0] p;
    rdy = s2 ? i2.in_ready : i1.in_ready;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s_ready got %b exp 1", nm, rdy); end
    if (s2) begin i2.in_valid = 1'b1; i2.in_signed = sg; i2.in_a = a; i2.in_b = b; end
    else    begin i1.in_valid = 1'b1; i1.in_signed = sg; i1.in_a = a; i1.in_b = b; end
    @(negedge clk);
    if (s2) begin i2.in_valid = 1'b0; i2.in_a = ~a; i2.in_b = ~b; i2.in_signed = ~sg; end
    else    begin i1.in_valid = 1'b0; i1.in_a = ~a; i1.in_b = ~b; i1.in_signed = ~sg; end
    n = 0;
    ov = s2 ? i2.out_valid : i1.out_valid;
    while (ov !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
      ov = s2 ? i2.out_valid : i1.out_valid;
    end
    checks++; if (n != lat) begin errors++; $display("FAIL %s_latency got %0d exp %0d", nm, n, lat); end
    p = s2 ? i2.out_p : i1.out_p;
    checks++; if (p !== exp) begin errors++; $display("FAIL %s_product got %h exp %h", nm, p, exp); end
    if (s2) i2.out_ready = 1'b1; else i1.out_ready = 1'b1;
    @(negedge clk);
    if (s2) i2.out_ready = 1'b0; else i1.out_ready = 1'b0;
    ov = s2 ? i2.out_valid : i1.out_valid;
    rdy = s2 ? i2.in_ready : i1.in_ready;
    checks++; if ({ov, rdy} !== 2'b01) begin errors++; $display("FAIL %s_consume got valid/ready %b exp 01", nm, {ov, rdy}); end
  endtask

  task automatic test_step1();
    op8(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, "s1_ff_ff");
    op8(1'b0, 1'b1, 8'h80, 8'h80, 16'h4000, 8, "s1_min_min");
    op8(1'b0, 1'b1, 8'hFF, 8'h01, 16'hFFFF, 8, "s1_neg1_1");
    op8(1'b0, 1'b0, 8'hFF, 8'h01, 16'h00FF, 8, "s1_u_ff_1");
    op8(1'b0, 1'b1, 8'h00, 8'h85, 16'h0000, 8, "s1_zero");
    op8(1'b0, 1'b1, 8'h7F, 8'h80, 16'hC080, 8, "s1_max_min");
  endtask

  task automatic test_step2();
    op8(1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 4, "s2_ff_ff");
    op8(1'b1, 1'b1, 8'h80, 8'h80, 16'h4000, 4, "s2_min_min");
    op8(1'b1, 1'b1, 8'hFD, 8'h07, 16'hFFEB, 4, "s2_neg3_7");
  endtask

  task automatic test_hold();
    int n;
    i1.in_valid = 1'b1; i1.in_signed = 1'b0; i1.in_a = 8'h12; i1.in_b = 8'h34;
    @(negedge clk);
    n = 0;
    while (i1.out_valid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL hold_first_latency got %0d exp 8", n); end
    for (int i = 0; i < 5; i++) begin
      i1.in_a = 8'(i * 17 + 1);
      @(negedge clk);
      checks++; if (i1.out_p !== 16'h03A8) begin errors++; $display("FAIL hold_p_%0d got %h exp 03a8", i, i1.out_p); end
      checks++; if ({i1.out_valid, i1.in_ready} !== 2'b10) begin errors++; $display("FAIL hold_ctl_%0d got %b exp 10", i, {i1.out_valid, i1.in_ready}); end
    end
    i1.in_a = 8'h03; i1.in_b = 8'h05; i1.out_ready = 1'b1;
    @(negedge clk);
    i1.out_ready = 1'b0;
    checks++; if ({i1.out_valid, i1.in_ready, i1.busy} !== 3'b010) begin errors++; $display("FAIL hold_consume_ctl got %b exp 010", {i1.out_valid, i1.in_ready, i1.busy}); end
    checks++; if (i1.out_p !== 16'h03A8) begin errors++; $display("FAIL hold_retain_p got %h exp 03a8", i1.out_p); end
    @(negedge clk);
    i1.in_valid = 1'b0;
    checks++; if ({i1.in_ready, i1.busy} !== 2'b01) begin errors++; $display("FAIL hold_next_accept got %b exp 01", {i1.in_ready, i1.busy}); end
    n = 0;
    while (i1.out_valid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL hold_next_latency got %0d exp 8", n); end
    checks++; if (i1.out_p !== 16'h000F) begin errors++; $display("FAIL hold_next_p got %h exp 000f", i1.out_p); end
    i1.out_ready = 1'b1;
    @(negedge clk);
    i1.out_ready = 1'b0;
  endtask

  task automatic test_abort();
    int seen;
    i1.in_valid = 1'b1; i1.in_signed = 1'b0; i1.in_a = 8'hAB; i1.in_b = 8'hCD;
    @(negedge clk);
    i1.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if ({i1.in_ready, i1.busy, i1.out_valid} !== 3'b100) begin errors++; $display("FAIL abort_ctl got %b exp 100", {i1.in_ready, i1.busy, i1.out_valid}); end
    checks++; if (i1.out_p !== 16'h0) begin errors++; $display("FAIL abort_p got %h exp 0000", i1.out_p); end
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (i1.out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_product got %0d valid cycles exp 0", seen); end
    op8(1'b0, 1'b0, 8'h03, 8'h05, 16'h000F, 8, "abort_next");
  endtask

  task automatic op_big(input logic sg, input logic [1023:0] a, input logic [31:0] b,
                        input logic [1055:0] exp, input string nm);
    int n;
    i3.in_valid = 1'b1; i3.in_signed = sg; i3.in_a = a; i3.in_b = b;
    @(negedge clk);
    i3.in_valid = 1'b0; i3.in_a = ~a;
    n = 0;
    while (i3.out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n != 32) begin errors++; $display("FAIL %s_latency got %0d exp 32", nm, n); end
    checks++; if (i3.out_p !== exp) begin errors++; $display("FAIL %s_product got_lo %h exp_lo %h", nm, i3.out_p[127:0], exp[127:0]); end
    i3.out_ready = 1'b1;
    @(negedge clk);
    i3.out_ready = 1'b0;
  endtask

  task automatic test_default();
    op_big(1'b0, '0, 32'hDEADBEEF, '0, "big_zero_a");
    op_big(1'b1, {32{32'h89ABCDEF}}, 32'h0, '0, "big_zero_b");
    op_big(1'b0, {1024{1'b1}}, 32'hFFFFFFFF, {32'hFFFFFFFE, {992{1'b1}}, 32'h00000001}, "big_all_ones");
    op_big(1'b1, {1'b1, 1023'b0}, 32'h80000000, {1'b0, 1'b1, 1054'b0}, "big_min_min");
  endtask

  task automatic test_back_to_back();
    logic [1055:0] exq[$];
    int            acq[$];
    logic [1023:0] a;
    logic [31:0]   b;
    logic          sg;
    logic [1055:0] e;
    int cyc, nsent, ndone, last_done, c0;
    cyc = 0; nsent = 0; ndone = 0; last_done = -1;
    i3.out_ready = 1'b1;
    while (ndone < 200 && cyc < 8000) begin
      if (i3.in_ready === 1'b1 && nsent < 200) begin
        for (int w = 0; w < 32; w++) a[w*32 +: 32] = $urandom;
        b  = $urandom;
        sg = 1'($urandom_range(0, 1));
        exq.push_back(ref_mul(sg, a, b));
        acq.push_back(cyc);
        i3.in_valid = 1'b1; i3.in_signed = sg; i3.in_a = a; i3.in_b = b;
        nsent++;
      end else if (nsent >= 200) begin
        i3.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (i3.out_valid === 1'b1 && exq.size() > 0) begin
        e  = exq.pop_front();
        c0 = acq.pop_front();
        checks++; if (i3.out_p !== e) begin errors++; $display("FAIL b2b_product_%0d got_lo %h exp_lo %h", ndone, i3.out_p[127:0], e[127:0]); end
        checks++; if (cyc - c0 - 1 != 32) begin errors++; $display("FAIL b2b_latency_%0d got %0d exp 32", ndone, cyc - c0 - 1); end
        if (last_done >= 0) begin
          checks++; if (cyc - last_done != 34) begin errors++; $display("FAIL b2b_period_%0d got %0d exp 34", ndone, cyc - last_done); end
        end
        last_done = cyc;
        ndone++;
      end
    end
    i3.in_valid = 1'b0;
    i3.out_ready = 1'b0;
    checks++; if (ndone != 200) begin errors++; $display("FAIL b2b_count got %0d exp 200", ndone); end
  endtask

  initial begin
    i1.in_valid = 1'b0; i1.in_signed = 1'b0; i1.in_a = '0; i1.in_b = '0; i1.out_ready = 1'b0;
    i2.in_valid = 1'b0; i2.in_signed = 1'b0; i2.in_a = '0; i2.in_b = '0; i2.out_ready = 1'b0;
    i3.in_valid = 1'b0; i3.in_signed = 1'b0; i3.in_a = '0; i3.in_b = '0; i3.out_ready = 1'b0;
    test_reset();
    test_step1();
    test_step2();
    test_hold();
    test_abort();
    test_default();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_mul_param.md
SERIAL_MUL_PARAM -- requirements
Module: serial_mul_param

Interface
REQ-001 SHALL have parameter A_W, default 1024: multiplicand width in bits.
REQ-002 SHALL have parameter B_W, default 32: multiplier width in bits.
REQ-003 SHALL have parameter STEP, default 1: multiplier bits retired per clock; legal values 1, 2, 4.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operands valid.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port in_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
REQ-009 SHALL have port in_a  input  A_W  multiplicand.
REQ-010 SHALL have port in_b  input  B_W  multiplier.
REQ-011 SHALL have port out_valid  output  1  product valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts product.
REQ-013 SHALL have port out_p  output  A_W+B_W  product.
REQ-014 SHALL have port busy  output  1  high in RUN state.

Function
REQ-015 SHALL fail elaboration when B_W mod STEP != 0 or STEP not in {1,2,4}.
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; N = B_W/STEP.
REQ-017 SHALL drive in_ready=1 only in IDLE; busy=1 only in RUN; out_valid=1 only in DONE.
REQ-018 SHALL accept operands on the edge where in_valid&&in_ready, latching in_a, in_b, in_signed, clearing partial product and step counter, entering RUN.
REQ-019 SHALL ignore in_a, in_b, in_signed, in_valid outside the accepting edge.
REQ-020 SHALL in RUN retire STEP multiplier bits per cycle, LSB first, by shift-add of the latched multiplicand.
REQ-021 SHALL enter DONE exactly N edges after the accepting edge; out_p updated on that edge.
REQ-022 SHALL make out_p the exact product, (A_W+B_W) bits, with operands interpreted per latched in_signed; no truncation or overflow for any operand pair, including signed min*min.
REQ-023 SHALL hold out_valid and out_p stable in DONE while out_ready=0, for any number of cycles.
REQ-024 SHALL return to IDLE on the edge where out_valid&&out_ready; in_ready rises in the following cycle.
REQ-025 SHALL not accept new operands in the same cycle a product is consumed; in_valid held high across consumption is accepted on the first IDLE edge.
REQ-026 SHALL retain out_p after consumption until the next product is written; out_valid is the sole qualifier.
REQ-027 SHALL produce 0 when either operand is 0, with unchanged latency N.
REQ-028 SHALL have a throughput of one product per N+2 cycles when in_valid and out_ready are held high.

Reset
REQ-029 SHALL on rstn=0, regardless of clock, force state IDLE, counter 0, partial product 0, out_p=0, out_valid=0, busy=0, in_ready=1.
REQ-030 SHALL abort any in-flight RUN or DONE operation on reset, with no product emitted; first operation after release behaves normally.

Verification
REQ-031 SHALL cover A_W=8, B_W=8, STEP=1, unsigned 0xFF*0xFF -> out_p=0xFE01, out_valid 8 edges after accept; with STEP=2 -> same value after 4 edges.
REQ-032 SHALL cover A_W=B_W=8 signed 0x80*0x80 -> 0x4000; signed 0xFF*0x01 -> 0xFFFF; unsigned 0xFF*0x01 -> 0x00FF.
REQ-033 SHALL cover out_ready held low 5 cycles in DONE with in_valid=1 and changing in_a -> out_p, out_valid stable, in_ready=0, then accept next operands one cycle after consumption.
REQ-034 SHALL cover rstn pulsed low at RUN step 3 -> all outputs to reset values asynchronously, no out_valid; next operation 3*5 -> 15 with correct latency.
REQ-035 SHALL cover default parameters with 0*x, (2^1024-1)*(2^32-1) unsigned, and 200 random signed/unsigned pairs vs reference model -> exact match, latency 32 each, back-to-back period 34.
